// File: rtl/nibble_pkg.sv
`default_nettype none
// ============================================================================
// Module  : nibble_pkg
// Purpose : Shared types and default sizes for the nibble execute stage.
//           Holds the opcode encoding, the execute FSM state encoding and the
//           default DW / PCW / RAM_AW values used by the interface and RTL.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package nibble_pkg;

  localparam int DW_DEF     = 8;  // data width
  localparam int PCW_DEF    = 4;  // program counter / decoded addr width
  localparam int RAM_AW_DEF = 5;  // RAM address width

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_ADD   = 3'b001,
    OP_SUB   = 3'b010,
    OP_AND   = 3'b011,
    OP_LOAD  = 3'b100,
    OP_STORE = 3'b101,
    OP_JMP   = 3'b110,
    OP_JZ    = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_EXEC     = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_HALT     = 2'd3
  } exec_state_t;

  // Opcodes whose result comes from the ALU and updates acc and both flags.
  function automatic logic is_alu_op(input op_t o);
    return (o == OP_ADD) || (o == OP_SUB) || (o == OP_AND);
  endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_exec_if.sv
`default_nettype none
// ============================================================================
// Module  : nibble_exec_if
// Purpose : Bundles the decoder handshake, PC register and RAM port signals
//           of the execute stage.
// Ports   : master - decoder/PC/RAM environment side
//           slave  - execute stage side
//   instr_valid/instr_ready  instruction handshake
//   op/x/y/addr/pc_cur       decoded fields and current PC
//   pc_next/pc_load          PC register update
//   ram_addr/ram_we/ram_wdata/ram_rdata  synchronous RAM port (1-cycle read)
// Revision: 1.0  initial release
// ============================================================================
interface nibble_exec_if
  import nibble_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int PCW    = PCW_DEF,
  parameter int RAM_AW = RAM_AW_DEF
);

  logic              instr_valid;
  logic              instr_ready;
  logic [2:0]        op;
  logic [DW-1:0]     x;
  logic [DW-1:0]     y;
  logic [PCW-1:0]    addr;
  logic [PCW-1:0]    pc_cur;
  logic [PCW-1:0]    pc_next;
  logic              pc_load;
  logic [RAM_AW-1:0] ram_addr;
  logic              ram_we;
  logic [DW-1:0]     ram_wdata;
  logic [DW-1:0]     ram_rdata;

  modport master (
    output instr_valid, op, x, y, addr, pc_cur, ram_rdata,
    input  instr_ready, pc_next, pc_load, ram_addr, ram_we, ram_wdata
  );

  modport slave (
    input  instr_valid, op, x, y, addr, pc_cur, ram_rdata,
    output instr_ready, pc_next, pc_load, ram_addr, ram_we, ram_wdata
  );

endinterface
`default_nettype wire

// File: rtl/nibble_alu.sv
`default_nettype none
// ============================================================================
// Module  : nibble_alu
// Purpose : Combinational ALU for ADD / SUB / AND. Other opcodes return a
//           zero result with carry clear; the caller ignores them.
// Ports   : op      in   opcode
//           x, y    in   operands (DW bits)
//           result  out  DW-bit result
//           carry   out  ADD carry-out / SUB borrow (x < y) / 0 for AND
//           zero    out  result == 0
// Revision: 1.0  initial release
// ============================================================================
module nibble_alu
  import nibble_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  op_t           op,
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] y,
  output logic [DW-1:0] result,
  output logic          carry,
  output logic          zero
);

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: {carry, result} = {1'b0, x} + {1'b0, y};
      OP_SUB: begin
        result = x - y;
        carry  = (x < y);
      end
      OP_AND: result = x & y;
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

  assign zero = (result == '0);

endmodule
`default_nettype wire

// File: rtl/nibble_exec.sv
`default_nettype none
// ============================================================================
// Module  : nibble_exec
// Purpose : Execute/control stage behind the instruction decoder. Accepts one
//           decoded instruction in IDLE, executes it in EXEC (plus MEM_WAIT
//           for LOAD), owns the accumulator and Z/C flags, and drives the PC
//           register update and the synchronous RAM port. A JMP to its own
//           address parks the block in HALT until reset.
// Ports   : clock      in   rising-edge clock
//           reset      in   asynchronous active-high reset
//           bus        --   nibble_exec_if.slave (handshake, PC, RAM)
//           acc        out  accumulator
//           flag_z     out  zero flag
//           flag_c     out  carry/borrow flag
//           halt       out  sticky halt indicator
//           retire_cnt out  16-bit count of pc_load cycles
//                           (only with NIBBLE_EXEC_RETIRE_CNT_EN defined)
// Config  : NIBBLE_EXEC_RETIRE_CNT_EN - adds the retire counter port.
// Revision: 1.0  initial release
// ============================================================================
module nibble_exec
  import nibble_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int PCW    = PCW_DEF,
  parameter int RAM_AW = RAM_AW_DEF
) (
  input  logic          clock,
  input  logic          reset,
  nibble_exec_if.slave  bus,
  output logic [DW-1:0] acc,
  output logic          flag_z,
  output logic          flag_c,
  output logic          halt
`ifdef NIBBLE_EXEC_RETIRE_CNT_EN
  ,
  output logic [15:0]   retire_cnt
`endif
);

  exec_state_t       state;
  exec_state_t       state_next;

  // Fields captured on acceptance; EXEC works only from these.
  op_t               op_q;
  logic [DW-1:0]     x_q;
  logic [DW-1:0]     y_q;
  logic [PCW-1:0]    addr_q;
  logic [PCW-1:0]    pc_q;

  logic [PCW-1:0]    pc_inc;
  logic [RAM_AW-1:0] addr_ext;
  logic              accept;

  logic [DW-1:0]     alu_result;
  logic              alu_carry;
  logic              alu_zero;

  logic              instr_ready;
  logic              pc_load;
  logic [PCW-1:0]    pc_next;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [DW-1:0]     ram_wdata;

  assign pc_inc   = pc_q + PCW'(1);   // wraps modulo 2^PCW
  assign addr_ext = RAM_AW'(addr_q);  // zero-extend decoded addr
  assign accept   = (state == S_IDLE) && bus.instr_valid;

  nibble_alu #(
    .DW(DW)
  ) u_alu (
    .op     (op_q),
    .x      (x_q),
    .y      (y_q),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and Moore outputs. Strobes and buses idle at zero so that a
  // reset in any state immediately drops ram_we / pc_load.
  // --------------------------------------------------------------------------
  always_comb begin
    state_next  = state;
    instr_ready = 1'b0;
    pc_load     = 1'b0;
    pc_next     = '0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;
    halt        = 1'b0;

    case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (bus.instr_valid) begin
          state_next = S_EXEC;
        end
      end

      S_EXEC: begin
        state_next = S_IDLE;
        case (op_q)
          OP_NOP, OP_ADD, OP_SUB, OP_AND: begin
            pc_load = 1'b1;
            pc_next = pc_inc;
          end
          OP_LOAD: begin
            // Address goes out now; data returns next cycle in MEM_WAIT.
            ram_addr   = addr_ext;
            state_next = S_MEM_WAIT;
          end
          OP_STORE: begin
            ram_we    = 1'b1;
            ram_addr  = addr_ext;
            ram_wdata = acc;
            pc_load   = 1'b1;
            pc_next   = pc_inc;
          end
          OP_JMP: begin
            // A jump to itself is the program's stop request.
            if (addr_q == pc_q) begin
              state_next = S_HALT;
            end else begin
              pc_load = 1'b1;
              pc_next = addr_q;
            end
          end
          OP_JZ: begin
            pc_load = 1'b1;
            pc_next = flag_z ? addr_q : pc_inc;
          end
          default: begin
            pc_load = 1'b1;
            pc_next = pc_inc;
          end
        endcase
      end

      S_MEM_WAIT: begin
        pc_load    = 1'b1;
        pc_next    = pc_inc;
        state_next = S_IDLE;
      end

      S_HALT: begin
        halt = 1'b1;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign bus.instr_ready = instr_ready;
  assign bus.pc_load     = pc_load;
  assign bus.pc_next     = pc_next;
  assign bus.ram_we      = ram_we;
  assign bus.ram_addr    = ram_addr;
  assign bus.ram_wdata   = ram_wdata;

  // --------------------------------------------------------------------------
  // Instruction capture, accumulator and flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q   <= OP_NOP;
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
      pc_q   <= '0;
      acc    <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= op_t'(bus.op);
        x_q    <= bus.x;
        y_q    <= bus.y;
        addr_q <= bus.addr;
        pc_q   <= bus.pc_cur;
      end

      if ((state == S_EXEC) && is_alu_op(op_q)) begin
        acc    <= alu_result;
        flag_c <= alu_carry;
        flag_z <= alu_zero;
      end

      // LOAD completion: carry is left untouched.
      if (state == S_MEM_WAIT) begin
        acc    <= bus.ram_rdata;
        flag_z <= (bus.ram_rdata == '0);
      end
    end
  end

`ifdef NIBBLE_EXEC_RETIRE_CNT_EN
  // Counts every PC update; entering HALT has no pc_load so is not counted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retire_cnt <= '0;
    end else if (pc_load) begin
      retire_cnt <= retire_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/nibble_exec.md
Name: nibble_exec

Overview:
- Execute/control stage directly downstream of the instruction decoder.
- Consumes decoded fields (op, x, y, addr) and performs the ALU operation, or the RAM load/store.
- Produces the next-PC value and load strobe for the PC register.
- Multi-cycle FSM; holds the accumulator and the Z/C flags.

Parameters:
- DW, 8, data width of x, y, accumulator and RAM data.
- PCW, 4, program-counter and decoded addr width.
- RAM_AW, 5, RAM address width; addr is zero-extended to RAM_AW.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr_valid  in  1  decoded fields valid this cycle.
- instr_ready  out  1  block can accept an instruction.
- op  in  3  decoded opcode.
- x  in  DW  operand A.
- y  in  DW  operand B.
- addr  in  PCW  jump target or RAM address.
- pc_cur  in  PCW  current PC register value.
- pc_next  out  PCW  value for the PC register data input.
- pc_load  out  1  PC register loads pc_next this cycle.
- ram_addr  out  RAM_AW  RAM address.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  DW  RAM write data (accumulator).
- ram_rdata  in  DW  RAM read data; synchronous RAM, 1-cycle latency.
- acc  out  DW  accumulator.
- flag_z  out  1  zero flag.
- flag_c  out  1  carry/borrow flag.
- halt  out  1  sticky halt indicator.

Behaviour:
- Reset (async, any state):
  - state=IDLE; acc=0, flag_z=0, flag_c=0, halt=0.
  - Captured op/x/y/addr=0.
  - All strobes (pc_load, ram_we) deasserted; pc_next=0; ram_addr=0; ram_wdata=0.
- States: IDLE, EXEC, MEM_WAIT, HALT. Outputs are Moore, driven from state plus captured fields.
- IDLE:
  - instr_ready=1.
  - When instr_valid=1, capture op/x/y/addr and pc_cur, then go to EXEC.
- EXEC: instr_ready=0. Behaviour by opcode:
  - 000 NOP: pc_load=1, pc_next=pc+1 -> IDLE.
  - 001 ADD: {C,acc}=x+y (DW+1 bits); Z=(acc==0); pc+1 -> IDLE.
  - 010 SUB: acc=x-y mod 2^DW; C=(x<y) borrow; Z updated; pc+1 -> IDLE.
  - 011 AND: acc=x&y; C=0; Z updated; pc+1 -> IDLE.
  - 100 LOAD: ram_addr=addr; no PC load this cycle -> MEM_WAIT.
  - 101 STORE: ram_we=1 for exactly one cycle, ram_addr=addr, ram_wdata=acc; pc+1; flags unchanged -> IDLE.
  - 110 JMP:
    - If addr==captured pc: go to HALT; pc_load=0; halt=1 from the next cycle.
    - Otherwise: pc_load=1, pc_next=addr -> IDLE.
  - 111 JZ: pc_next = flag_z ? addr : pc+1; pc_load=1 -> IDLE.
- MEM_WAIT:
  - acc=ram_rdata; Z=(ram_rdata==0); C unchanged.
  - pc_load=1, pc_next=pc+1 -> IDLE.
- HALT:
  - instr_ready=0, halt=1.
  - No strobes; instr_valid is ignored. Exit only via reset.
- Timing and width rules:
  - pc+1 wraps modulo 2^PCW (15 -> 0).
  - Latency: 2 cycles per instruction (IDLE+EXEC); LOAD takes 3.
  - pc_load and ram_we never assert in the same cycle as instr_ready.
- Reset mid-operation: any pending LOAD/STORE is abandoned; no ram_we pulse follows reset deassertion.
- instr_valid held high across IDLE: each acceptance starts a new instruction.
- instr_valid outside IDLE: ignored.

Optional Feature:
- Macro: NIBBLE_EXEC_RETIRE_CNT_EN.
- When defined:
  - Adds output retire_cnt [15:0], reset to 0.
  - Increments by 1 on every cycle with pc_load=1, wrapping at 16'hFFFF -> 0.
  - Does not count entering HALT.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package nibble_pkg holds:
  - Opcode enum op_t: OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_LOAD, OP_STORE, OP_JMP, OP_JZ.
  - FSM enum exec_state_t.
  - DW/PCW/RAM_AW defaults.
- One sub-module, nibble_alu: combinational; takes op/x/y and returns result, carry, zero for ADD/SUB/AND.
- FSM, accumulator and flags stay in nibble_exec.

Test Plan:
- Reset mid-STORE: assert reset during EXEC with op=101 -> ram_we=0 and acc=0 immediately; instr_ready=1 after release.
- ADD carry: x=8'hF0, y=8'h20 -> acc=8'h10, C=1, Z=0, pc_next=pc+1, pc_load pulses at cycle 2.
- SUB borrow then JZ: x=5, y=5 -> acc=0, Z=1, C=0. Then JZ with addr=4'h9 -> pc_next=9. Repeat with Z=0 and pc=4'hF -> pc_next=0 (wrap).
- STORE/LOAD round trip:
  - acc=8'hA5, STORE addr=3 -> single ram_we pulse, ram_addr=5'h03, ram_wdata=8'hA5.
  - Then LOAD addr=3 -> acc=8'hA5 at MEM_WAIT+1; total 3 cycles.
- Halt: pc_cur=7, JMP addr=7 -> halt=1 sticky, instr_ready=0; instr_valid pulses ignored for 20 cycles; reset clears halt.
- Retire counter (macro defined): 5 retired instructions -> retire_cnt=5. Preload near 16'hFFFF -> wraps to 0.
